// File: rtl/jio_pkg.sv
// Shared constants for jcscpu IO-bus devices: device addresses and
// keyboard status-byte bit positions.
package jio_pkg;

  localparam logic [7:0] IO_DEV_TTY = 8'd0;
  localparam logic [7:0] IO_DEV_KBD = 8'd1;

  localparam int ST_AVAIL = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_OVF   = 5;

  // The status byte only has room for a 3-bit occupancy field.
  function automatic logic [2:0] sat_count3(input int unsigned n);
    logic [2:0] r;
    r = (n > 7) ? 3'd7 : n[2:0];
    return r;
  endfunction

endpackage

// File: rtl/jfifo.sv
// Synchronous FIFO with registered storage; a push while full is accepted
// only when a pop happens on the same edge.
module jfifo #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/jkbd_in.sv
// Keyboard input device on the jcscpu IO bus: queues board bytes and serves
// IN Data / IN Addr. Optional status byte and read-to-clear via JKBD_STATUS_EN.
module jkbd_in
  import jio_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = IO_DEV_KBD,
  parameter int         DEPTH    = 4,
  localparam int        CW       = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [7:0]    bus_in,
  input  logic          io_s,
  input  logic          io_e,
  input  logic          io_da,
  input  logic          io_io,
  input  logic          push,
  input  logic [7:0]    push_data,
  output logic [7:0]    bus_out,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  // Bus protocol: io_s is a set strobe sampled on each CLK edge; io_e opens a
  // read window during which bus_out is driven combinationally. A window's
  // single side effect (pop / overflow clear) happens on the edge it closes.
  logic [7:0] dev_q;
  logic       rd_q;
  logic       ovf_q, ovf_d;
  logic       addr_wr, sel, rd_data;
  logic       pop_ok, push_ok, drop;
  logic [7:0] head;

  assign addr_wr = io_s & io_da & io_io;
  assign sel     = (dev_q == DEV_ADDR);
  assign rd_data = io_e & ~io_da & ~io_io & sel;

  assign pop_ok  = rd_q & ~rd_data & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;

  jfifo #(.DEPTH(DEPTH), .DW(8)) u_fifo (
    .clk   (CLK),
    .rst   (reset),
    .push  (push),
    .pop   (pop_ok),
    .din   (push_data),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

`ifdef JKBD_STATUS_EN
  logic       rd_stat;
  logic       stat_q;
  logic [7:0] stat_byte;

  assign rd_stat = io_e & io_da & ~io_io & sel;

  always_comb begin
    stat_byte           = '0;
    stat_byte[ST_AVAIL] = ~empty;
    stat_byte[ST_FULL]  = full;
    stat_byte[ST_OVF]   = ovf_q;
    stat_byte[2:0]      = sat_count3(32'(count));
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) stat_q <= 1'b0;
    else       stat_q <= rd_stat;
  end
`endif

  always_comb begin
    bus_out = 8'h00;
    if (rd_data) bus_out = empty ? 8'h00 : head;
`ifdef JKBD_STATUS_EN
    else if (rd_stat) bus_out = stat_byte;
`endif
  end

  // A drop on the same edge as a status read-out wins, so it is never lost.
  always_comb begin
    ovf_d = ovf_q;
`ifdef JKBD_STATUS_EN
    if (stat_q & ~rd_stat) ovf_d = 1'b0;
`endif
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      dev_q <= 8'h00;
      rd_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (addr_wr) dev_q <= bus_in;
      rd_q  <= rd_data;
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_jkbd_in.sv
// Bench for jkbd_in: byte-queue reference model feeding a scoreboard queue,
// checked by a negedge monitor; honours JKBD_STATUS_EN.
module tb_jkbd_in;

  localparam int         DEPTH = 4;
  localparam logic [7:0] DEV   = 8'd1;
  localparam int         W     = 14;

  logic       CLK;
  logic       reset;
  logic [7:0] bus_in;
  logic       io_s, io_e, io_da, io_io;
  logic       push;
  logic [7:0] push_data;
  logic [7:0] bus_out;
  logic [2:0] count;
  logic       empty, full, overflow;

  jkbd_in #(.DEV_ADDR(DEV), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .bus_in    (bus_in),
    .io_s      (io_s),
    .io_e      (io_e),
    .io_da     (io_da),
    .io_io     (io_io),
    .push      (push),
    .push_data (push_data),
    .bus_out   (bus_out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // expected vector: {bus_out[7:0], count[2:0], empty, full, overflow}
  logic [W-1:0] exp_q[$];

  // reference model
  logic [7:0] m_q[$];
  logic [7:0] m_dev = 8'h00;
  bit         m_prev_rd = 0;
  bit         m_prev_st = 0;
  bit         m_ovf = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dev = 8'h00;
    m_prev_rd = 0;
    m_prev_st = 0;
    m_ovf = 0;
  endtask

  // One bus cycle: drive inputs, queue the expected outputs, advance the model.
  task automatic drive(input bit rst_v, input bit s, input bit e, input bit da, input bit io,
                       input logic [7:0] b, input bit p, input logic [7:0] pd);
    bit         sel, rdd, rds, popped, drop;
    int         n;
    logic [7:0] eb;
    reset = rst_v; io_s = s; io_e = e; io_da = da; io_io = io;
    bus_in = b; push = p; push_data = pd;
    if (rst_v) model_reset();
    sel = (m_dev == DEV);
    rdd = e & ~da & ~io & sel;
    rds = e & da & ~io & sel;
    n = m_q.size();
    eb = 8'h00;
    if (rdd) eb = (n > 0) ? m_q[0] : 8'h00;
`ifdef JKBD_STATUS_EN
    else if (rds) eb = {n != 0, n == DEPTH, m_ovf, 2'b00, (n > 7) ? 3'd7 : 3'(n)};
`endif
    exp_q.push_back({eb, 3'(n), n == 0, n == DEPTH, m_ovf});
    @(posedge CLK);
    if (!rst_v) begin
      popped = 0;
      drop = 0;
      if (m_prev_rd && !rdd && n > 0) begin
        void'(m_q.pop_front());
        popped = 1;
      end
      if (p) begin
        if (n < DEPTH || popped) m_q.push_back(pd);
        else drop = 1;
      end
`ifdef JKBD_STATUS_EN
      if (m_prev_st && !rds) m_ovf = 0;
`endif
      if (drop) m_ovf = 1;
      if (s && da && io) m_dev = b;
      m_prev_rd = rdd;
      m_prev_st = rds;
    end
    #1;
  endtask

  task automatic idle(input int n, input bit p = 0, input logic [7:0] pd = 8'h00);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 8'h00, p, pd);
  endtask
  task automatic out_addr(input logic [7:0] a);
    drive(0, 1, 0, 1, 1, a, 0, 8'h00);
  endtask
  task automatic push_byte(input logic [7:0] d);
    drive(0, 0, 0, 0, 0, 8'h00, 1, d);
  endtask
  task automatic in_data(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1, 0, 0, 8'h00, 0, 8'h00);
  endtask
  task automatic in_stat(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1, 1, 0, 8'h00, 0, 8'h00);
  endtask
  task automatic rand_window(input bit s, input bit e, input bit da, input bit io,
                             input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++)
      drive(0, s, e, da, io, b, $urandom_range(0, 2) == 0, 8'($urandom));
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    logic [W-1:0] ev;
    if (exp_q.size() != 0) begin
      ev = exp_q.pop_front();
      chk("bus_out", bus_out, ev[13:6]);
      chk("count", 8'(count), 8'(ev[5:3]));
      chk("empty", 8'(empty), 8'(ev[2]));
      chk("full", 8'(full), 8'(ev[1]));
      chk("overflow", 8'(overflow), 8'(ev[0]));
    end
  end

  initial begin
    reset = 1; io_s = 0; io_e = 0; io_da = 0; io_io = 0;
    bus_in = 0; push = 0; push_data = 0;
    @(posedge CLK); #1;

    drive(1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    drive(1, 0, 0, 0, 0, 8'h00, 0, 8'h00);

    // deselected after reset: reads return nothing
    in_data(3); idle(1);
    chk("deselected_count", 8'(count), 8'd0);

    // long IN Data window pops exactly one byte
    out_addr(8'h01);
    push_byte(8'hA5); push_byte(8'h3C);
    in_data(5); idle(1);
    chk("one_pop_count", 8'(count), 8'd1);
    in_data(1); idle(1);

    // overfill
    for (int i = 0; i < 5; i++) push_byte(8'h11 + 8'(i));
    idle(1);
    chk("overfill_full", 8'(full), 8'd1);
    chk("overfill_ovf", 8'(overflow), 8'd1);
`ifdef JKBD_STATUS_EN
    in_stat(1);
    chk("status_byte", bus_out, 8'hE4);
    in_stat(1); idle(1);
    chk("ovf_cleared", 8'(overflow), 8'd0);
`else
    in_stat(2); idle(1);
    chk("ovf_sticky", 8'(overflow), 8'd1);
`endif

    // full FIFO: push on the pop edge
    in_data(1);
    idle(1, 1, 8'h77);
    chk("full_swap_count", 8'(count), 8'd4);
    for (int i = 0; i < 4; i++) begin in_data(2); idle(1); end
    chk("drained_count", 8'(count), 8'd0);

    // empty FIFO read, push on window-end edge
    in_data(1);
    idle(1, 1, 8'h5A);
    chk("empty_push_count", 8'(count), 8'd1);
    in_data(1); idle(1);

    // deselect, then reset mid-window
    out_addr(8'h00);
    in_data(2); idle(1);
    chk("tty_sel_count", 8'(count), 8'd0);
    out_addr(8'h01);
    push_byte(8'h55);
    in_data(2);
    drive(1, 0, 1, 0, 0, 8'h00, 0, 8'h00);
    chk("reset_bus", bus_out, 8'h00);
    chk("reset_count", 8'(count), 8'd0);
    idle(1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    out_addr(($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 2)) : DEV);
        2, 3, 4: rand_window(0, 1, 0, 0, 8'h00, $urandom_range(1, 5));
        5:       rand_window(0, 1, 1, 0, 8'h00, $urandom_range(1, 3));
        9:       if ($urandom_range(0, 9) == 0) drive(1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
                 else rand_window(0, 0, 0, 0, 8'h00, 1);
        default: rand_window(0, 0, 0, 0, 8'h00, $urandom_range(1, 3));
      endcase
    end
    idle(2);

    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge CLK);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jkbd_in.md
# jkbd_in

Byte-wide keyboard input device for the jcscpu IO bus: the input-side counterpart of the TTY output port. It queues bytes pushed by the board (switch value captured on a debounced button click) in a small FIFO. It answers the CPU's IN Data / IN Addr instructions by driving the queue head or a status byte onto the wired-OR CPU bus, and pops exactly one byte per IN Data instruction. It sits beside the TTY logic in the top level, sharing the `io_s`/`io_e`/`io_da`/`io_io` control-unit outputs.

## Interface
Parameters:
- `DEV_ADDR`, 8'd1: IO device address this block answers to. Address 0 is the TTY.
- `DEPTH`, 4: FIFO entries. Must be a power of 2, ≥2.

Ports (one clock; reset is asynchronous and active-high):
- `CLK` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: async active-high; clears all state.
- `bus_in` in 8: CPU bus value.
- `io_s` in 1: CU IO set strobe.
- `io_e` in 1: CU IO enable strobe.
- `io_da` in 1: 1 = address cycle, 0 = data cycle.
- `io_io` in 1: 1 = output (CPU→device), 0 = input.
- `push` in 1: one-CLK strobe from the button click detector.
- `push_data` in 8: byte to enqueue (e.g. `SW[7:0]`).
- `bus_out` out 8: contribution to the wired-OR bus; 8'h00 whenever not driving.
- `count` out $clog2(DEPTH)+1: entries held.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == DEPTH`.
- `overflow` out 1: sticky; a push was dropped.

## Operation
- Decodes:
  - addr_wr = `io_s & io_da & io_io`.
  - sel = (`dev_q == DEV_ADDR`).
  - rd_data = `io_e & ~io_da & ~io_io & sel`.
  - rd_stat = `io_e & io_da & ~io_io & sel`.
- `dev_q` (8-bit):
  - Loads `bus_in` on every CLK edge where addr_wr = 1, whatever the address value. Any OUT Addr to another device deselects this block.
- `bus_out`:
  - rd_data: FIFO head, or 8'h00 if empty.
  - rd_stat: status byte {`~empty`, `full`, `overflow`, 2'b00, count[2:0]} (count saturates at 7 in this field).
  - Otherwise 8'h00.
- Pop:
  - `rd_q` registers rd_data.
  - Pop fires on the edge where `rd_q & ~rd_data`, i.e. the falling end of the enable window, and only if not empty.
  - One pop per IN Data however many CLK cycles `io_e` stays high.
- Push:
  - Enqueues `push_data` when not full, or when full and a pop occurs on the same edge.
  - Otherwise the byte is dropped and `overflow` is set.
- Simultaneous push and pop: both take effect; `count` is unchanged.
  - Empty + push + pop-fire: the pop is ignored because the FIFO was empty before the edge; the push lands and `count` becomes 1.
- `overflow` clears on reset or on the falling end of an rd_stat window (read-to-clear, same edge-detect as pop).
- Read and write pointers are AW bits and wrap modulo `DEPTH`.

## Timing
- Reset values:
  - `dev_q` = 8'h00, so the block is deselected.
  - `rd_q` = 0, pointers = 0, `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0.
  - `bus_out` = 8'h00.
- `bus_out` is combinational from the registered head/status and the live decode: valid in the same cycle `io_e` rises, with zero latency.
- A pushed byte is visible at the head one CLK after the push edge.
- Reset asserted mid-read: the FIFO is emptied, no pop is recorded, and `bus_out` drops to 0 immediately.

## Configuration
- `JKBD_STATUS_EN`:
  - Defined: rd_stat drives the status byte, and `overflow` is read-to-clear as above.
  - Undefined: rd_stat drives 8'h00; `overflow` stays sticky until reset; the status decode logic is not generated.

## Structure
- Package `jio_pkg`:
  - Device address constants `IO_DEV_TTY` = 0 and `IO_DEV_KBD` = 1.
  - Status bit index constants `ST_AVAIL` = 7, `ST_FULL` = 6, `ST_OVF` = 5.
- Sub-module `jfifo`:
  - Parameterised sync FIFO with `push`, `pop`, `din`, `dout` (head), `count`, `empty`, `full`.
  - Registered storage; accepts push-when-full only together with a pop.
- `jkbd_in` owns the decode, `dev_q`, the edge detects and `overflow`.

## Test plan
- Reset, then IN Data with `dev_q` = 0 → `bus_out` stays 8'h00 throughout, `count` stays 0.
- OUT Addr 8'h01; push 8'hA5, 8'h3C; IN Data with `io_e` held 5 CLKs → `bus_out` = 8'hA5 for all 5 cycles, one pop, head = 8'h3C, `count` = 1.
- Push 5 bytes (DEPTH=4) → `full` = 1, `count` = 4, `overflow` = 1, 5th byte lost; with the macro, IN Addr reads 8'hE4, then `overflow` = 0 after the window.
- FIFO full; push 8'h77 on the same edge a pop fires → `count` stays 4, no overflow, 8'h77 becomes the tail.
- Empty FIFO; IN Data → `bus_out` = 8'h00, `count` stays 0; push during the same edge as the window end → `count` = 1.
- OUT Addr 8'h00 (TTY) after selecting the block → IN Data ignored; assert `reset` mid-window → `bus_out` = 0 at once, `count` = 0.
